// File: rtl/imem_loader.sv
// Byte-stream program loader and 10-byte fetch window for the Y86 instruction memory.
// Optional running-sum check of the payload: define IMEM_CHECKSUM_EN.
module imem_loader #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        reload,
    input  logic [63:0] pc,
    output logic [79:0] instr,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] prog_len
);

    localparam int FETCH_BYTES        = 10;
    localparam int AW                 = $clog2(MEM_BYTES);
    localparam logic [15:0] MEM_LEN   = 16'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_RUN,
        S_ERR,
        S_CHK
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    lenLo_q, lenLo_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [15:0]   progLen_q, progLen_d;
    logic          coreHold_q, loadDone_q, loadErr_q;
    logic          wrEn;
    logic [15:0]   newLen;
    logic [7:0]    mem [MEM_BYTES];
    logic [64:0]   rdAddr [FETCH_BYTES];

`ifdef IMEM_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    sumNext;
`endif

    assign newLen = {in_data, lenLo_q};

    // Transfer happens whenever in_valid is seen in a state that advertises ready.
    always_comb begin
        state_d   = state_q;
        lenLo_d   = lenLo_q;
        ptr_d     = ptr_q;
        progLen_d = progLen_q;
        wrEn      = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        sum_d     = sum_q;
        sumNext   = sum_q + in_data;
`endif
        case (state_q)
            S_LEN_LO: begin
`ifdef IMEM_CHECKSUM_EN
                sum_d = '0;
`endif
                if (in_valid) begin
                    lenLo_d = in_data;
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (in_valid) begin
                    progLen_d = newLen;
                    ptr_d     = '0;
                    if (newLen > MEM_LEN) begin
                        state_d = S_ERR;
                    end else if (newLen == 16'd0) begin
`ifdef IMEM_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_RUN;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (in_valid) begin
                    wrEn  = 1'b1;
                    ptr_d = ptr_q + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                    sum_d = sumNext;
`endif
                    if (16'(ptr_q) == progLen_q - 16'd1) begin
`ifdef IMEM_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_RUN;
`endif
                    end
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_d = S_LEN_LO;
                end
            end
`ifdef IMEM_CHECKSUM_EN
            S_CHK: begin
                if (in_valid) begin
                    state_d = (sumNext == 8'd0) ? S_RUN : S_ERR;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Status flags are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_LEN_LO;
            lenLo_q    <= '0;
            ptr_q      <= '0;
            progLen_q  <= '0;
            coreHold_q <= 1'b1;
            loadDone_q <= 1'b0;
            loadErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lenLo_q    <= lenLo_d;
            ptr_q      <= ptr_d;
            progLen_q  <= progLen_d;
            coreHold_q <= (state_d != S_RUN);
            loadDone_q <= (state_d == S_RUN);
            loadErr_q  <= (state_d == S_ERR);
        end
    end

`ifdef IMEM_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Contents survive reset so a reload only overwrites the new program's range.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem[ptr_q] <= in_data;
        end
    end

    // Bytes past the program or the array read as halt; 65-bit sum keeps pc+k from wrapping.
    always_comb begin
        instr = '0;
        for (int k = 0; k < FETCH_BYTES; k++) begin
            rdAddr[k] = {1'b0, pc} + 65'(k);
            if (state_q == S_RUN &&
                rdAddr[k] < {49'b0, progLen_q} &&
                rdAddr[k] < 65'(MEM_BYTES)) begin
                instr[8*k +: 8] = mem[rdAddr[k][AW-1:0]];
            end
        end
    end

    assign in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CHK);
    assign core_hold = coreHold_q;
    assign load_done = loadDone_q;
    assign load_err  = loadErr_q;
    assign prog_len  = progLen_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-fetch interface: accepts a program as a byte stream and stores it in byte-addressed instruction memory.
- Serves the fetch stage a 10-byte little-endian instruction window at PC.
- Holds the processor in reset (core_hold) until a complete, valid program is loaded; a reload can be requested later.
- Sits between the bench/UART byte source and the SEQ fetch stage.

Parameters:
- MEM_BYTES, 1024: instruction memory size in bytes; legal program length 0..MEM_BYTES.
- FETCH_BYTES, 10: bytes returned per fetch (longest Y86 instruction); fixed at 10, not to be overridden.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte source has in_data available.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid && in_ready.
- reload  input  1  single-cycle request to load a new program; honoured only in RUN.
- pc  input  64  fetch address from the PC update stage.
- instr  output  80  bytes mem[pc..pc+9]; byte k in bits [8k+7:8k].
- core_hold  output  1  high: processor must be held in reset.
- load_done  output  1  high in RUN.
- load_err  output  1  high in ERR.
- prog_len  output  16  byte count of the current or last accepted program length header.

Behaviour:
- Stream format: LEN_LO, LEN_HI (16-bit little-endian length N), then N payload bytes written to addresses 0..N-1.
- States: LEN_LO, LEN_HI, DATA, RUN, ERR. All outputs are registered except instr and in_ready.
- Reset (any state, including mid-DATA):
  - state=LEN_LO, prog_len=0, write pointer=0.
  - core_hold=1, load_done=0, load_err=0.
  - Memory array is not cleared.
- LEN_LO: on transfer, latch the low byte and go to LEN_HI.
- LEN_HI: on transfer, form N.
  - N > MEM_BYTES -> ERR.
  - N == 0 -> RUN (or CHK when the optional feature is enabled).
  - Otherwise -> DATA with pointer=0.
  - prog_len=N is registered on this transfer in all cases, including the error case.
- DATA: on each transfer, write mem[ptr]=in_data and increment ptr. The transfer with ptr==N-1 moves to RUN.
- Cycles with in_valid=0 cause no state change and no write. The source may gap arbitrarily.
- in_ready = 1 in LEN_LO, LEN_HI, DATA (and CHK); 0 in RUN and ERR. in_ready is combinational from state only, with no dependence on in_valid.
- RUN:
  - core_hold=0 and load_done=1, both registered.
  - core_hold falls in the cycle after the final byte is accepted (1-cycle latency).
- reload while in RUN:
  - next state LEN_LO, core_hold=1, load_done=0.
  - prog_len holds its old value until the new LEN_HI transfer.
  - reload in any other state is ignored.
- ERR: sticky. core_hold=1, load_err=1; left only by reset.
- instr is a combinational read.
  - Bytes at address >= prog_len, or >= MEM_BYTES, read as 0x00 (Y86 halt). Address arithmetic is 64-bit with no wrap.
  - In any state other than RUN, instr=0.
- Write and read of the same address in one cycle cannot occur, because core_hold gates fetch.

Optional Feature:
- IMEM_CHECKSUM_EN defined:
  - A state CHK follows the last payload byte (or follows LEN_HI when N==0).
  - The loader keeps an 8-bit running sum of payload bytes (mod 256), reset to 0 at LEN_LO.
  - The CHK transfer goes to RUN if (sum + byte) mod 256 == 0, else to ERR.
- Undefined: no CHK state; the last payload byte goes directly to RUN, and no sum logic is synthesized.

Test Plan:
- Load sequence 0A 00 30 F2 05 00 00 00 00 00 00 00 with no gaps:
  - 12 transfers; core_hold=0 and load_done=1 the next cycle; prog_len=10.
  - pc=0 -> instr=0x0000_0000_0000_0005_F230.
  - pc=8 -> instr=0x0000.
- Length 0 (00 00):
  - RUN after 2 transfers; instr=0 at pc=0; in_ready=0 afterwards.
- Length 0x0401 with MEM_BYTES=1024:
  - ERR after LEN_HI; load_err=1, core_hold=1, in_ready=0; further in_valid ignored.
- Reset mid-load: send 03 00 11 22, pulse reset, then load 01 00 AA:
  - RUN; prog_len=1; instr at pc=0 = 0xAA; pc=1 reads 0 (not stale 22).
- In RUN, pulse reload, then load 02 00 10 20 with in_valid toggling every other cycle:
  - core_hold=1 during the load with no spurious writes.
  - Final state RUN; instr at pc=0 = 0x2010.
- With IMEM_CHECKSUM_EN:
  - 02 00 10 20 D0 -> RUN.
  - 02 00 10 20 D1 -> ERR with load_err=1.
